// File: rtl/bsort100_accel_if.sv
// Control and dual-channel slave memory bus of the bsort100 accelerator.
// The accelerator attaches through the slave modport; the driving environment uses master.
interface bsort100_accel_if;
  logic         start_port;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [19:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  modport slave (
    input  start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    output done_port, Sout_Rdata_ram, Sout_DataRdy
  );

  modport master (
    output start_port, S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    input  done_port, Sout_Rdata_ram, Sout_DataRdy
  );
endinterface

// File: rtl/bsort100_accel.sv
// bsort100 kernel: fills a 100-word signed array with a descending sequence and bubble-sorts it,
// while exposing the array on a two-channel byte-addressable slave port.
module bsort100_accel #(
  parameter int unsigned MEM_var_26078_26084 = 256
) (
  input logic             clock,
  input logic             reset,
  bsort100_accel_if.slave bus
);
  localparam int unsigned N = 100;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SORT, S_DONE} state_t;

  state_t      state, state_nx;
  logic [6:0]  idx, idx_nx, idx_p1;
  logic [6:0]  pass, pass_nx;
  logic        swapped, swapped_nx;
  logic        do_init, do_swap, pass_end;
  logic [31:0] word_a, word_b;
  logic [31:0] mem [N];

  logic [1:0]  acc_ok;
  logic [6:0]  acc_word   [2];
  logic [3:0]  acc_be     [2];
  logic [31:0] acc_wbytes [2];
  logic [31:0] acc_rd     [2];

  logic [1:0]  rd_v1, rd_v2, wr_ack;
  logic [31:0] rd_d1 [2];
  logic [31:0] rd_d2 [2];

  logic        unused_wdata_hi;
  assign unused_wdata_hi = ^{bus.S_Wdata_ram[127:96], bus.S_Wdata_ram[63:32]};

  assign idx_p1 = idx + 7'd1;
  assign word_a = mem[idx];
  assign word_b = (idx_p1 < 7'd100) ? mem[idx_p1] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      pass    <= '0;
      swapped <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      pass    <= pass_nx;
      swapped <= swapped_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pass_nx    = pass;
    swapped_nx = swapped;
    do_init    = 1'b0;
    do_swap    = 1'b0;
    pass_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_port) begin
          state_nx = S_INIT;
          idx_nx   = '0;
        end
      end
      S_INIT: begin
        do_init = 1'b1;
        if (idx == 7'd99) begin
          state_nx   = S_SORT;
          idx_nx     = '0;
          pass_nx    = '0;
          swapped_nx = 1'b0;
        end else begin
          idx_nx = idx_p1;
        end
      end
      S_SORT: begin
        // One compare-and-swap per cycle; the swap flag includes the current compare.
        do_swap  = $signed(word_a) > $signed(word_b);
        pass_end = (idx == 7'd98 - pass);
        if (pass_end) begin
          if ((!swapped && !do_swap) || pass == 7'd98) begin
            state_nx = S_DONE;
          end else begin
            pass_nx    = pass + 7'd1;
            idx_nx     = '0;
            swapped_nx = 1'b0;
          end
        end else begin
          idx_nx     = idx_p1;
          swapped_nx = swapped | do_swap;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.done_port = (state == S_DONE);

  // Per-channel decode: window, size and word-crossing checks, byte enables and read extraction.
  always_comb begin
    logic [9:0]  a;
    logic [9:0]  rel;
    logic [1:0]  off;
    logic        fit;
    logic [31:0] mask;
    a      = '0;
    rel    = '0;
    off    = '0;
    fit    = 1'b0;
    mask   = '0;
    acc_ok = '0;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      acc_word[ch]   = '0;
      acc_be[ch]     = '0;
      acc_wbytes[ch] = '0;
      acc_rd[ch]     = '0;
      a    = bus.S_addr_ram[10*ch +: 10];
      rel  = a - 10'(MEM_var_26078_26084);
      off  = rel[1:0];
      fit  = 1'b0;
      mask = '0;
      case (bus.S_data_ram_size[7*ch +: 7])
        7'd8: begin
          fit        = 1'b1;
          mask       = 32'h0000_00FF;
          acc_be[ch] = 4'b0001 << off;
        end
        7'd16: begin
          fit        = (off != 2'd3);
          mask       = 32'h0000_FFFF;
          acc_be[ch] = 4'b0011 << off;
        end
        7'd32: begin
          fit        = (off == 2'd0);
          mask       = '1;
          acc_be[ch] = '1;
        end
        default: ;
      endcase
      acc_ok[ch] = ({22'd0, a} >= MEM_var_26078_26084) && (rel < 10'd400) && fit;
      if (acc_ok[ch]) begin
        acc_word[ch]   = rel[8:2];
        acc_wbytes[ch] = bus.S_Wdata_ram[64*ch +: 32] << {off, 3'b000};
        acc_rd[ch]     = (mem[rel[8:2]] >> {off, 3'b000}) & mask;
      end
    end
  end

  // Slave writes land only in IDLE, so they never collide with kernel writes; ch1 is applied last.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (do_init) mem[idx] <= ~{25'd0, idx};
      if (do_swap) begin
        mem[idx]    <= word_b;
        mem[idx_p1] <= word_a;
      end
      if (state == S_IDLE) begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
          if (bus.S_we_ram[ch] && acc_ok[ch]) begin
            for (int unsigned b = 0; b < 4; b++) begin
              if (acc_be[ch][b]) mem[acc_word[ch]][8*b +: 8] <= acc_wbytes[ch][8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_v1  <= '0;
      rd_v2  <= '0;
      wr_ack <= '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        rd_d1[ch] <= '0;
        rd_d2[ch] <= '0;
      end
    end else begin
      rd_v2 <= rd_v1;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        rd_v1[ch]  <= bus.S_oe_ram[ch] && !bus.S_we_ram[ch];
        rd_d1[ch]  <= (bus.S_oe_ram[ch] && !bus.S_we_ram[ch]) ? acc_rd[ch] : '0;
        rd_d2[ch]  <= rd_d1[ch];
        wr_ack[ch] <= bus.S_we_ram[ch];
      end
    end
  end

  assign bus.Sout_DataRdy   = rd_v2 | wr_ack;
  assign bus.Sout_Rdata_ram = {32'd0, rd_d2[1], 32'd0, rd_d2[0]};
endmodule

// File: tb/tb_bsort100_accel.sv
// Bench for bsort100_accel: directed and random slave traffic checked against a byte-level
// memory model, plus sort runs compared with a queue-sorted reference.
module tb_bsort100_accel;
  localparam int BASE = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bsort100_accel_if bus ();

  bsort100_accel #(.MEM_var_26078_26084(BASE)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int double_done = 0;
  logic done_prev = 1'b0;
  logic [7:0] ref_b [400];

  always @(negedge clock) begin
    if (bus.done_port) done_cnt++;
    if (bus.done_port && done_prev) double_done++;
    done_prev = bus.done_port;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic bit m_ok(input int rel, input int size);
    if (rel < 0 || rel >= 400) return 1'b0;
    if (size != 8 && size != 16 && size != 32) return 1'b0;
    return (rel / 4) == ((rel + size / 8 - 1) / 4);
  endfunction

  function automatic logic [63:0] m_read(input int addr, input int size);
    logic [63:0] v;
    int rel;
    v = '0;
    rel = addr - BASE;
    if (!m_ok(rel, size)) return '0;
    for (int k = 0; k < size / 8; k++) v[8*k +: 8] = ref_b[rel + k];
    return v;
  endfunction

  task automatic m_write(input int addr, input int size, input logic [31:0] wd);
    int rel;
    rel = addr - BASE;
    if (m_ok(rel, size))
      for (int k = 0; k < size / 8; k++) ref_b[rel + k] = wd[8*k +: 8];
  endtask

  task automatic m_sorted();
    int q[$];
    logic [31:0] w;
    for (int i = 0; i < 100; i++) q.push_back(-(i + 1));
    q.sort();
    for (int k = 0; k < 100; k++) begin
      w = q[k];
      for (int b = 0; b < 4; b++) ref_b[4*k + b] = w[8*b +: 8];
    end
  endtask

  task automatic bus_idle();
    bus.start_port      = 1'b0;
    bus.S_oe_ram        = '0;
    bus.S_we_ram        = '0;
    bus.S_addr_ram      = '0;
    bus.S_Wdata_ram     = '0;
    bus.S_data_ram_size = '0;
  endtask

  task automatic set_ch(input int ch, input logic oe, input logic we, input int addr,
                        input int size, input logic [31:0] wd);
    logic [31:0] junk;
    junk = $urandom;
    bus.S_oe_ram[ch] = oe;
    bus.S_we_ram[ch] = we;
    bus.S_addr_ram[10*ch +: 10] = addr[9:0];
    bus.S_data_ram_size[7*ch +: 7] = size[6:0];
    bus.S_Wdata_ram[64*ch +: 64] = {junk, wd};
  endtask

  task automatic rd(input int ch, input int addr, input int size, input string tag);
    logic [63:0] want;
    want = m_read(addr, size);
    @(negedge clock); bus_idle(); set_ch(ch, 1'b1, 1'b0, addr, size, '0);
    @(negedge clock); bus_idle();
    check({tag, "_early"}, bus.Sout_DataRdy[ch], 64'd0);
    @(negedge clock);
    check({tag, "_rdy"}, bus.Sout_DataRdy[ch], 64'd1);
    check({tag, "_data"}, bus.Sout_Rdata_ram[64*ch +: 64], want);
  endtask

  task automatic wr(input int ch, input int addr, input int size, input logic [31:0] wd,
                    input bit honoured, input string tag);
    @(negedge clock); bus_idle(); set_ch(ch, 1'b0, 1'b1, addr, size, wd);
    @(negedge clock); bus_idle();
    check({tag, "_ack"}, bus.Sout_DataRdy[ch], 64'd1);
    if (honoured) m_write(addr, size, wd);
  endtask

  task automatic start_pulse();
    @(negedge clock); bus_idle(); bus.start_port = 1'b1;
    @(negedge clock); bus.start_port = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!bus.done_port && cyc < 50000) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_done_seen"}, bus.done_port, 64'd1);
    @(negedge clock);
    check({tag, "_done_1cyc"}, bus.done_port, 64'd0);
    m_sorted();
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < 100; k++) rd(0, BASE + 4*k, 32, tag);
  endtask

  initial begin
    int cyc, n0, ch, addr, size;
    bus_idle();
    repeat (2) @(negedge clock);
    check("rst_done", bus.done_port, 64'd0);
    check("rst_rdy", bus.Sout_DataRdy, 64'd0);
    check("rst_rdata_lo", bus.Sout_Rdata_ram[63:0], 64'd0);
    check("rst_rdata_hi", bus.Sout_Rdata_ram[127:64], 64'd0);
    reset = 1'b0;

    // Writes before start are overwritten by the fill.
    for (int i = 0; i < 5; i++) wr(i % 2, BASE + 4 * $urandom_range(0, 99), 32, $urandom, 1'b1, "pre");

    start_pulse();
    wait_done("sort1", cyc);
    check("sort1_in_budget", 64'(cyc < 50000), 64'd1);
    check("sort1_all_passes", 64'(cyc >= 5050), 64'd1);
    check("sort1_count", 64'(done_cnt), 64'd1);
    read_all("sorted1");

    @(negedge clock); bus_idle();
    set_ch(0, 1'b1, 1'b0, 256, 32, '0);
    set_ch(1, 1'b1, 1'b0, 652, 32, '0);
    @(negedge clock); bus_idle();
    check("dual_early", bus.Sout_DataRdy, 64'd0);
    @(negedge clock);
    check("dual_rdy", bus.Sout_DataRdy, 64'd3);
    check("dual_d0", bus.Sout_Rdata_ram[63:0], 64'h0000_0000_FFFF_FF9C);
    check("dual_d1", bus.Sout_Rdata_ram[127:64], 64'h0000_0000_FFFF_FFFF);

    wr(0, 257, 8, 32'h12, 1'b1, "byte_wr");
    rd(0, 256, 32, "byte_rd");
    check("byte_model", m_read(256, 32), 64'h0000_0000_FFFF_129C);
    rd(0, 100, 32, "below_win");
    rd(1, BASE + 399, 8, "last_byte");
    rd(1, BASE + 400, 8, "past_win");
    rd(0, BASE + 2, 32, "misal32");
    rd(1, BASE + 7, 16, "cross16");
    rd(0, BASE + 6, 16, "half_hi");
    rd(0, BASE + 12, 24, "size24");
    wr(0, BASE + 3, 16, 32'hABCD, 1'b1, "misal_wr");
    wr(1, BASE + 20, 24, 32'h1234_5678, 1'b1, "bad_size_wr");
    rd(0, BASE, 32, "misal_wr_chk");
    rd(0, BASE + 20, 32, "bad_size_chk");

    // Same byte from both channels: ch1 must win.
    @(negedge clock); bus_idle();
    set_ch(0, 1'b0, 1'b1, BASE + 8, 8, 32'hAA);
    set_ch(1, 1'b0, 1'b1, BASE + 8, 16, 32'hBBCC);
    @(negedge clock); bus_idle();
    check("both_wr_ack", bus.Sout_DataRdy, 64'd3);
    m_write(BASE + 8, 8, 32'hAA);
    m_write(BASE + 8, 16, 32'hBBCC);
    rd(1, BASE + 8, 32, "both_wr_chk");

    // oe and we together behave as a write with no read response.
    @(negedge clock); bus_idle(); set_ch(0, 1'b1, 1'b1, BASE + 16, 32, 32'hCAFE_F00D);
    @(negedge clock); bus_idle();
    check("oewe_ack", bus.Sout_DataRdy[0], 64'd1);
    @(negedge clock);
    check("oewe_norsp", bus.Sout_DataRdy[0], 64'd0);
    m_write(BASE + 16, 32, 32'hCAFE_F00D);
    rd(0, BASE + 16, 32, "oewe_chk");

    for (int i = 0; i < 40; i++) begin
      ch = $urandom_range(0, 1);
      addr = BASE - 8 + $urandom_range(0, 415);
      case ($urandom_range(0, 4))
        0: size = 8;
        1: size = 16;
        4: size = 24;
        default: size = 32;
      endcase
      if ($urandom_range(0, 1) == 1) wr(ch, addr, size, $urandom, 1'b1, "rnd_wr");
      else rd(ch, addr, size, "rnd_rd");
    end
    read_all("rnd_all");

    // Reset during the sort aborts without a done pulse.
    n0 = done_cnt;
    start_pulse();
    repeat (400) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6000) @(negedge clock);
    check("abort_no_done", 64'(done_cnt - n0), 64'd0);
    start_pulse();
    wait_done("sort2", cyc);
    check("sort2_count", 64'(done_cnt - n0), 64'd1);
    read_all("sorted2");

    // Start and slave writes during the run are ignored but acknowledged.
    n0 = done_cnt;
    start_pulse();
    repeat (300) @(negedge clock);
    start_pulse();
    wr(0, BASE, 32, 32'h5555_5555, 1'b0, "busy_wr0");
    wr(1, BASE + 40, 8, 32'h07, 1'b0, "busy_wr1");
    wait_done("sort3", cyc);
    repeat (6000) @(negedge clock);
    check("sort3_count", 64'(done_cnt - n0), 64'd1);
    read_all("sorted3");
    check("no_double_done", 64'(double_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
